// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with redirect, flush window and halt.
// Ports: clock, reset (sync, high); branch/zero/jump/halt/stall controls;
//   offset (signed displacement), target (jump address) in;
//   pc, flush, taken, halted registered out.
module pc_sequencer #(
   parameter int ADDR_W       = 8,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              branch,
   input  logic              zero,
   input  logic              jump,
   input  logic              halt,
   input  logic              stall,
   input  logic [ADDR_W-1:0] offset,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc,
   output logic              flush,
   output logic              taken,
   output logic              halted
);

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      HALTED
   } state_t;

   localparam logic [3:0] CNT_LOAD =
      4'(FLUSH_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ONE =
      ADDR_W'(1);

   state_t            state_q;
   state_t            state_d;
   logic [3:0]        cnt_q;
   logic [3:0]        cnt_d;
   logic [ADDR_W-1:0] pc_d;
   logic              taken_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc;
      taken_d = 1'b0;
      unique case (state_q)
         RUN: begin
            if (halt) begin
               state_d = HALTED;
            end else if (stall) begin
               pc_d = pc;
            end else if (jump) begin
               pc_d    = target;
               taken_d = 1'b1;
               state_d = FLUSH;
               cnt_d   = CNT_LOAD;
            end else if (branch && zero) begin
               // Modulo add doubles as signed add.
               pc_d    = pc + offset;
               taken_d = 1'b1;
               state_d = FLUSH;
               cnt_d   = CNT_LOAD;
            end else begin
               pc_d = pc + ONE;
            end
         end
         FLUSH: begin
            if (halt) begin
               state_d = HALTED;
            end else if (!stall) begin
               pc_d = pc + ONE;
               if (cnt_q == 4'd0) begin
                  state_d = RUN;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= 4'd0;
         pc      <= '0;
         flush   <= 1'b0;
         taken   <= 1'b0;
         halted  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc      <= pc_d;
         flush   <= (state_d == FLUSH);
         taken   <= taken_d;
         halted  <= (state_d == HALTED);
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed + random bench for pc_sequencer.
// Outputs are compared every cycle against a cycle-level reference model.
module tb_pc_sequencer;

   localparam int AW = 8;
   localparam int FC = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          branch = 1'b0;
   logic          zero = 1'b0;
   logic          jump = 1'b0;
   logic          halt = 1'b0;
   logic          stall = 1'b0;
   logic [AW-1:0] offset = '0;
   logic [AW-1:0] target = '0;
   logic [AW-1:0] pc;
   logic          flush;
   logic          taken;
   logic          halted;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: pc as integer, flush as cycles remaining.
   int m_pc     = 0;
   int m_rem    = 0;
   bit m_taken  = 0;
   bit m_halted = 0;

   pc_sequencer #(
      .ADDR_W(AW),
      .FLUSH_CYCLES(FC)
   ) dut (
      .clock (clock),
      .reset (reset),
      .branch(branch),
      .zero  (zero),
      .jump  (jump),
      .halt  (halt),
      .stall (stall),
      .offset(offset),
      .target(target),
      .pc    (pc),
      .flush (flush),
      .taken (taken),
      .halted(halted)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h",
                  tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      m_taken = 0;
      if (reset) begin
         m_pc     = 0;
         m_rem    = 0;
         m_halted = 0;
      end else if (m_halted) begin
         m_pc = m_pc;
      end else if (halt) begin
         m_halted = 1;
         m_rem    = 0;
      end else if (stall) begin
         m_pc = m_pc;
      end else if (m_rem > 0) begin
         m_pc  = (m_pc + 1) % 256;
         m_rem = m_rem - 1;
      end else if (jump) begin
         m_pc    = int'(target);
         m_taken = 1;
         m_rem   = FC;
      end else if (branch && zero) begin
         m_pc    = (m_pc + int'(offset)) % 256;
         m_taken = 1;
         m_rem   = FC;
      end else begin
         m_pc = (m_pc + 1) % 256;
      end
   endtask

   task automatic step(input bit r, input bit b,
                       input bit z, input bit j,
                       input bit h, input bit s,
                       input logic [AW-1:0] off,
                       input logic [AW-1:0] tgt);
      reset  = r;
      branch = b;
      zero   = z;
      jump   = j;
      halt   = h;
      stall  = s;
      offset = off;
      target = tgt;
      model_edge();
      @(posedge clock);
      #1;
      check("pc", 32'(pc), 32'(m_pc));
      check("flush", 32'(flush), 32'(m_rem > 0));
      check("taken", 32'(taken), 32'(m_taken));
      check("halted", 32'(halted), 32'(m_halted));
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
   endtask

   initial begin
      // Reset, then count up.
      step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      step(1, 1, 1, 1, 0, 0, 8'h33, 8'h77);
      check("rst_pc", 32'(pc), 32'h0);
      check("rst_flush", 32'(flush), 32'h0);
      for (int i = 1; i <= 4; i++) begin
         idle();
         check("idle_pc", 32'(pc), 32'(i));
      end
      idle();
      check("at5", 32'(pc), 32'h5);

      // Backward taken branch.
      step(0, 1, 1, 0, 0, 0, 8'hFD, 8'h00);
      check("br_pc", 32'(pc), 32'h2);
      check("br_taken", 32'(taken), 32'h1);
      check("br_flush", 32'(flush), 32'h1);
      idle();
      check("br_pc2", 32'(pc), 32'h3);
      check("br_fl2", 32'(flush), 32'h1);
      check("br_tk2", 32'(taken), 32'h0);
      idle();
      check("br_pc3", 32'(pc), 32'h4);
      check("br_fl3", 32'(flush), 32'h0);

      // Untaken branch.
      idle();
      step(0, 1, 0, 0, 0, 0, 8'hFD, 8'h00);
      check("nt_pc", 32'(pc), 32'h6);
      check("nt_taken", 32'(taken), 32'h0);
      check("nt_flush", 32'(flush), 32'h0);

      // Jump near top, jump ignored in flush, wrap.
      step(0, 0, 0, 1, 0, 0, 8'h00, 8'hFE);
      check("j_pc", 32'(pc), 32'hFE);
      step(0, 0, 0, 1, 0, 0, 8'h00, 8'hF0);
      check("j_pc2", 32'(pc), 32'hFF);
      check("j_fl2", 32'(flush), 32'h1);
      idle();
      check("j_wrap", 32'(pc), 32'h00);
      check("j_fl3", 32'(flush), 32'h0);

      // Stall holds a pending branch.
      for (int i = 0; i < 9; i++) idle();
      check("at9", 32'(pc), 32'h9);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, 0, 0, 1, 8'h10, 8'h00);
         check("st_pc", 32'(pc), 32'h9);
         check("st_tk", 32'(taken), 32'h0);
      end
      step(0, 1, 1, 0, 0, 0, 8'h10, 8'h00);
      check("st_rel", 32'(pc), 32'h19);
      check("st_tk2", 32'(taken), 32'h1);
      idle();
      idle();

      // Halt during flush, then reset recovers.
      step(0, 0, 0, 1, 0, 0, 8'h00, 8'h40);
      step(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
      check("h_halted", 32'(halted), 32'h1);
      check("h_flush", 32'(flush), 32'h0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 1, 1, 0, 0, 8'h05, 8'h22);
         check("h_pc", 32'(pc), 32'h40);
      end
      step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      check("h_rst_pc", 32'(pc), 32'h0);
      check("h_rst_hl", 32'(halted), 32'h0);
      idle();
      check("h_resume", 32'(pc), 32'h1);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(63) == 0,
              $urandom_range(2) == 0,
              $urandom_range(1) == 0,
              $urandom_range(5) == 0,
              $urandom_range(39) == 0,
              $urandom_range(3) == 0,
              8'($urandom),
              8'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter ADDR_W SHALL default to 8 and set the width of the program counter, offset and target.
REQ-003 Parameter FLUSH_CYCLES SHALL default to 2 and set the number of flush cycles after a redirect (legal range 1..15).
REQ-004 Port clock SHALL be an input, width 1: the system clock, rising edge active.
REQ-005 Port reset SHALL be an input, width 1: synchronous, active-high reset.
REQ-006 Port branch SHALL be an input, width 1: a conditional branch instruction is in execute.
REQ-007 Port zero SHALL be an input, width 1: the ALU zero flag, i.e. the branch condition.
REQ-008 Port jump SHALL be an input, width 1: an unconditional jump is in execute.
REQ-009 Port halt SHALL be an input, width 1: a halt instruction is in execute.
REQ-010 Port stall SHALL be an input, width 1: the datapath cannot accept a new fetch.
REQ-011 Port offset SHALL be an input, width ADDR_W: a two's-complement branch displacement.
REQ-012 Port target SHALL be an input, width ADDR_W: the absolute jump address.
REQ-013 Port pc SHALL be an output, width ADDR_W: the registered program counter.
REQ-014 Port flush SHALL be an output, width 1: squash the instructions in fetch and decode.
REQ-015 Port taken SHALL be an output, width 1: a one-cycle pulse marking a redirect.
REQ-016 Port halted SHALL be an output, width 1: the sequencer is stopped.

Function
REQ-017 The FSM SHALL have three states, RUN, FLUSH and HALTED, and all outputs SHALL be registered.
REQ-018 In RUN, each rising edge SHALL apply exactly one action, using the first match in this priority order:
- halt -> HALTED
- stall -> hold pc
- jump -> redirect to target
- branch&zero -> redirect to pc+offset
- otherwise -> pc+1
REQ-019 A redirect SHALL load pc with the new address, set taken=1 for exactly one cycle, enter FLUSH and load the flush counter with FLUSH_CYCLES-1.
REQ-020 branch=1 with zero=0 SHALL behave as sequential execution: pc+1, no taken, no flush.
REQ-021 flush SHALL be 1 exactly while the state is FLUSH, i.e. for FLUSH_CYCLES consecutive cycles starting the cycle taken is 1, with stall cycles extending it.
REQ-022 In FLUSH:
- pc SHALL advance by 1 per edge unless stall=1.
- branch and jump SHALL be ignored.
- The counter SHALL decrement on each non-stalled edge.
- The state SHALL return to RUN on the edge where the counter is 0.
REQ-023 halt SHALL be honoured in FLUSH as in RUN: enter HALTED, and flush goes to 0 on the same edge.
REQ-024 In HALTED, pc SHALL freeze and halted SHALL be 1; the state SHALL be left only by reset.
REQ-025 All pc arithmetic SHALL be modulo 2^ADDR_W: pc+1 wraps from all-ones to 0, and pc+offset wraps in both directions with no error indication.
REQ-026 Simultaneous jump and branch&zero SHALL resolve to jump.
REQ-027 stall SHALL not drop a pending redirect: while stall=1 nothing is taken, and the redirect occurs on the first non-stalled edge if its inputs are still asserted.

Reset
REQ-028 On a rising edge with reset=1, the block SHALL apply the following regardless of state or any other input:
- pc=0
- flush=0
- taken=0
- halted=0
- flush counter=0
- state=RUN
REQ-029 reset during FLUSH or HALTED SHALL abort that state immediately, and the first non-reset edge SHALL behave as RUN from pc=0.

Verification (ADDR_W=8, FLUSH_CYCLES=2)
REQ-030 The bench SHALL check: reset for 2 cycles, then 4 idle cycles -> pc sequence 0,1,2,3,4; flush, taken and halted stay 0.
REQ-031 The bench SHALL check: at pc=5, drive branch=1, zero=1, offset=8'hFD -> pc=2 with taken=1 and flush=1; next cycle pc=3, flush=1, taken=0; then pc=4 with flush=0.
REQ-032 The bench SHALL check: at pc=5, drive branch=1, zero=0 -> pc=6 with taken=0 and flush=0.
REQ-033 The bench SHALL check: jump to target=8'hFE -> pc=FE, then FF during flush with a jump to target=8'hF0 asserted and ignored, then 00 as the state returns to RUN.
REQ-034 The bench SHALL check: stall=1 with branch=1, zero=1 held for 3 cycles at pc=9 -> pc stays 9 and taken=0; on stall release pc=9+offset and taken=1.
REQ-035 The bench SHALL check: halt=1 during the first flush cycle -> halted=1, flush=0 and pc frozen for 5 cycles; then reset -> pc=0, halted=0, and counting resumes.
